// File: rtl/sprite_pkg.sv
// Shared sprite-subsystem definitions.
//   ROM_ADDR_W / PIX_W / NUM_SPRITE_REQ : default widths and the requester count
//   req_idx_e                           : fixed requester slot assignment
//   pixel_t                             : one RGB888 ROM word
package sprite_pkg;
  localparam int ROM_ADDR_W     = 14;
  localparam int PIX_W          = 24;
  localparam int NUM_SPRITE_REQ = 4;

  typedef enum logic [1:0] {
    REQ_MARIO = 2'd0,
    REQ_LUIGI = 2'd1,
    REQ_GOMBA = 2'd2,
    REQ_COIN  = 2'd3
  } req_idx_e;

  typedef logic [PIX_W-1:0] pixel_t;
endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Bus between the sprite fetchers / ROM and the arbiter.
//   req, req_addr, req_mask : fetcher requests (req_addr slice i = [i*ADDR_W +: ADDR_W])
//   gnt                     : one-hot combinational grant
//   mem_rd, mem_addr        : registered ROM read strobe and address
//   mem_rdata               : ROM read data
//   rvalid, rdata           : steered return word, one-hot owner
//   busy                    : a read is in flight
// slave = arbiter side, master = fetcher/ROM side.
interface sprite_rom_arbiter_if
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = NUM_SPRITE_REQ,
  parameter int ADDR_W  = ROM_ADDR_W,
  parameter int DATA_W  = PIX_W
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_mask;
  logic [NUM_REQ-1:0]        gnt;
  logic                      mem_rd;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_rdata;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;

  modport slave (
    input  req, req_addr, req_mask, mem_rdata,
    output gnt, mem_rd, mem_addr, rvalid, rdata, busy
  );

  modport master (
    output req, req_addr, req_mask, mem_rdata,
    input  gnt, mem_rd, mem_addr, rvalid, rdata, busy
  );
endinterface

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
//   i_elig   : eligible bitmap
//   i_ptr    : start position of the search (highest priority this cycle)
//   o_onehot : one-hot winner, 0 when nothing is eligible
//   o_idx    : binary winner index (0 when nothing is eligible)
//   o_any    : some bit was eligible
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_elig,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  logic [IW-1:0] w_cand;

  // Walk ptr, ptr+1, ... wrapping modulo N; the first eligible slot wins.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_cand   = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = IW'((32'(i_ptr) + 32'(k)) % 32'(N));
      if (!o_any && i_elig[w_cand]) begin
        o_any            = 1'b1;
        o_onehot[w_cand] = 1'b1;
        o_idx            = w_cand;
      end
    end
  end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing the sprite ROM read port among pixel fetchers.
//   Clk   : system clock, rising edge
//   Reset : asynchronous active-low reset
//   bus   : sprite_rom_arbiter_if.slave (requests, grant, ROM port, returns, busy)
// A grant in cycle T drives mem_rd/mem_addr in T+1; the ROM word is sampled at
// the end of cycle T+MEM_LAT and presented as rvalid/rdata in T+MEM_LAT+1.
// The rvalid register is the final stage of the tag pipeline; r_vld_pipe holds
// the MEM_LAT stages in front of it.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = NUM_SPRITE_REQ,
  parameter int ADDR_W  = ROM_ADDR_W,
  parameter int DATA_W  = PIX_W,
  parameter int MEM_LAT = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  sprite_rom_arbiter_if.slave  bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]          w_elig;
  logic [NUM_REQ-1:0]          w_pick_oh;
  logic [PW-1:0]               w_pick_idx;
  logic                        w_any;
  logic [ADDR_W-1:0]           w_addr;
  logic [PW-1:0]               w_ptr_nxt;

  logic [PW-1:0]               r_rr_ptr;
  logic                        r_mem_rd;
  logic [ADDR_W-1:0]           r_mem_addr;
  logic [MEM_LAT-1:0]          r_vld_pipe;
  logic [MEM_LAT-1:0][PW-1:0]  r_idx_pipe;
  logic [NUM_REQ-1:0]          r_rvalid;
  logic [DATA_W-1:0]           r_rdata;

  assign w_elig = bus.req & bus.req_mask;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .i_elig   (w_elig),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_any)
  );

  // Grant is suppressed while reset is held so no fetcher sees a phantom accept.
  assign bus.gnt = Reset ? w_pick_oh : '0;

  // One-hot OR-mux of the winner's address slice.
  always_comb begin
    w_addr = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_pick_oh[i]) w_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
  end

  assign w_ptr_nxt = (w_pick_idx == PW'(NUM_REQ-1)) ? '0 : w_pick_idx + 1'b1;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_rr_ptr   <= '0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_vld_pipe <= '0;
      r_idx_pipe <= '0;
      r_rvalid   <= '0;
      r_rdata    <= '0;
    end else begin
      r_mem_rd <= w_any;
      if (w_any) begin
        r_mem_addr <= w_addr;
        r_rr_ptr   <= w_ptr_nxt;
      end
      // Tag shift register: never stalls, one slot per issued read.
      r_vld_pipe[0] <= w_any;
      r_idx_pipe[0] <= w_pick_idx;
      for (int k = 1; k < MEM_LAT; k++) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        r_idx_pipe[k] <= r_idx_pipe[k-1];
      end
      // Last tag stage lines up with the ROM word; steer it to its owner.
      r_rvalid <= '0;
      if (r_vld_pipe[MEM_LAT-1]) begin
        r_rvalid[r_idx_pipe[MEM_LAT-1]] <= 1'b1;
        r_rdata                         <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_rd   = r_mem_rd;
  assign bus.mem_addr = r_mem_addr;
  assign bus.rvalid   = r_rvalid;
  assign bus.rdata    = r_rdata;
  // Reads still waiting for their ROM word; the return cycle itself is not busy.
  assign bus.busy     = |r_vld_pipe;
endmodule
